// File: rtl/kes_arb_pkg.sv
// Shared definitions for the KES channel arbiter: FSM state encoding,
// chunk counter constants and the one-hot to binary index helper.
package kes_arb_pkg;

  // One-hot FSM state encoding, held directly in the state register
  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_SELECT  = 5'b00010,
    ST_OUT     = 5'b00100,
    ST_DUMMY   = 5'b01000,
    ST_STANDBY = 5'b10000
  } arb_state_t;

  localparam int         CHUNK_CNT_W   = 8;
  localparam logic [7:0] CHUNK_CNT_MAX = 8'd255;

  // Binary index of the set bit in a one-hot vector of up to 16 lanes.
  // An all-zero vector maps to index 0.
  function automatic logic [3:0] oneHotToBin(input logic [15:0] oneHot);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = idx | (oneHot[i] ? i[3:0] : 4'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kes_arb_if.sv
// Request/grant bundle between the decoder channels and the KES arbiter.
interface kes_arb_if #(
  parameter int CHANNEL_COUNT = 4,
  parameter int CHANNEL_BITS  = 2
);
  logic [CHANNEL_COUNT-1:0] iRequestChannel;
  logic [CHANNEL_COUNT-1:0] iLastChunk;
  logic                     iKESAvail;
  logic [CHANNEL_COUNT-1:0] oKESAvail;
  logic [CHANNEL_BITS-1:0]  oChannelNumber;
  logic                     oChannelValid;
  logic                     oForcedRelease;

  // Arbiter side
  modport slave (
    input  iRequestChannel, iLastChunk, iKESAvail,
    output oKESAvail, oChannelNumber, oChannelValid, oForcedRelease
  );

  // Channel / solver side
  modport master (
    output iRequestChannel, iLastChunk, iKESAvail,
    input  oKESAvail, oChannelNumber, oChannelValid, oForcedRelease
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: the first requesting channel found
// scanning upward from the pointer, wrapping modulo CHANNEL_COUNT.
module rr_priority_picker
  import kes_arb_pkg::*;
#(
  parameter int CHANNEL_COUNT = 4,
  parameter int CHANNEL_BITS  = 2
) (
  input  logic [CHANNEL_COUNT-1:0] iRequest,
  input  logic [CHANNEL_BITS-1:0]  iPointer,
  output logic [CHANNEL_COUNT-1:0] oGrant,
  output logic [CHANNEL_BITS-1:0]  oIndex
);

  logic [CHANNEL_BITS-1:0] probe;
  logic                    found;
  logic [15:0]             grantWide;

  // Scan from the pointer; power-of-two channel count makes the add wrap
  always_comb begin
    oGrant = {CHANNEL_COUNT{1'b0}};
    found  = 1'b0;
    probe  = iPointer;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      probe = iPointer + i[CHANNEL_BITS-1:0];
      if (!found && iRequest[probe]) begin
        oGrant[probe] = 1'b1;
        found         = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Widen the grant to the helper's 16-lane input
  always_comb begin
    grantWide                  = 16'd0;
    grantWide[CHANNEL_COUNT-1:0] = oGrant;
  end

  assign oIndex = CHANNEL_BITS'(oneHotToBin(grantWide));

endmodule

// File: rtl/kes_channel_arbiter.sv
// Round-robin arbiter handing key-equation-solver chunk slots to decoder
// channels. A grant is held across chunks until the channel flags its last
// chunk, drops its request, or hits the MAX_CHUNKS limit.
module kes_channel_arbiter
  import kes_arb_pkg::*;
#(
  parameter int CHANNEL_COUNT = 4,
  parameter int CHANNEL_BITS  = 2,
  parameter int MAX_CHUNKS    = 16
) (
  input  logic      iClock,
  input  logic      iResetN,
  kes_arb_if.slave  bus
);

  localparam logic [CHUNK_CNT_W-1:0] CHUNK_LIMIT = CHUNK_CNT_W'(MAX_CHUNKS);
  localparam logic                   LIMIT_EN    = (MAX_CHUNKS != 0);

  arb_state_t                 rState;
  arb_state_t                 nextState;
  logic [CHANNEL_COUNT-1:0]   rGrant;
  logic [CHANNEL_COUNT-1:0]   rKesAvail;
  logic [CHANNEL_BITS-1:0]    rChannelNumber;
  logic [CHANNEL_BITS-1:0]    rPointer;
  logic [CHUNK_CNT_W-1:0]     rChunkCount;
  logic                       rChannelValid;
  logic                       rForcedRelease;

  logic [CHANNEL_COUNT-1:0]   pickGrant;
  logic [CHANNEL_BITS-1:0]    pickIndex;
  logic [CHANNEL_COUNT-1:0]   nextKesAvail;
  logic                       nextValid;
  logic                       nextForced;
  logic                       ownerLast;
  logic                       ownerRequest;
  logic                       limitHit;

  rr_priority_picker #(
    .CHANNEL_COUNT (CHANNEL_COUNT),
    .CHANNEL_BITS  (CHANNEL_BITS)
  ) uPicker (
    .iRequest (bus.iRequestChannel),
    .iPointer (rPointer),
    .oGrant   (pickGrant),
    .oIndex   (pickIndex)
  );

  assign ownerLast    = bus.iLastChunk[rChannelNumber];
  assign ownerRequest = bus.iRequestChannel[rChannelNumber];
  assign limitHit     = LIMIT_EN && (rChunkCount == CHUNK_LIMIT);

  // State register
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      rState <= ST_IDLE;
    end else begin
      rState <= nextState;
    end
  end

  // Next-state decision; an unknown encoding falls back to IDLE
  always_comb begin
    nextState = ST_IDLE;
    case (rState)
      ST_IDLE: begin
        if ((|bus.iRequestChannel) && bus.iKESAvail) nextState = ST_SELECT;
        else                                         nextState = ST_IDLE;
      end
      ST_SELECT: nextState = ST_OUT;
      ST_OUT:    nextState = ST_DUMMY;
      ST_DUMMY: begin
        if (ownerLast)     nextState = ST_IDLE;
        else if (limitHit) nextState = ST_IDLE;
        else               nextState = ST_STANDBY;
      end
      ST_STANDBY: begin
        // A dropped request abandons the grant even if the solver is ready
        if (!ownerRequest)      nextState = ST_IDLE;
        else if (bus.iKESAvail) nextState = ST_OUT;
        else                    nextState = ST_STANDBY;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from where the FSM is heading
  always_comb begin
    nextKesAvail = {CHANNEL_COUNT{1'b0}};
    nextValid    = 1'b0;
    nextForced   = 1'b0;
    if (nextState == ST_OUT) nextKesAvail = rGrant;
    else                     nextKesAvail = {CHANNEL_COUNT{1'b0}};
    if (nextState != ST_IDLE) nextValid = 1'b1;
    else                      nextValid = 1'b0;
    if ((rState == ST_DUMMY) && !ownerLast && limitHit) nextForced = 1'b1;
    else                                                nextForced = 1'b0;
  end

  // Registered outputs, grant capture, pointer advance and chunk counting
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      rKesAvail      <= {CHANNEL_COUNT{1'b0}};
      rChannelValid  <= 1'b0;
      rForcedRelease <= 1'b0;
      rGrant         <= {CHANNEL_COUNT{1'b0}};
      rChannelNumber <= {CHANNEL_BITS{1'b0}};
      rPointer       <= {CHANNEL_BITS{1'b0}};
      rChunkCount    <= {CHUNK_CNT_W{1'b0}};
    end else begin
      rKesAvail      <= nextKesAvail;
      rChannelValid  <= nextValid;
      rForcedRelease <= nextForced;
      if ((rState == ST_IDLE) && (nextState == ST_SELECT)) begin
        rGrant         <= pickGrant;
        rChannelNumber <= pickIndex;
        rPointer       <= pickIndex + CHANNEL_BITS'(1);
        rChunkCount    <= {CHUNK_CNT_W{1'b0}};
      end else if ((rState == ST_OUT) && (rChunkCount != CHUNK_CNT_MAX)) begin
        rChunkCount <= rChunkCount + CHUNK_CNT_W'(1);
      end else begin
        rChunkCount <= rChunkCount;
      end
    end
  end

  assign bus.oKESAvail      = rKesAvail;
  assign bus.oChannelNumber = rChannelNumber;
  assign bus.oChannelValid  = rChannelValid;
  assign bus.oForcedRelease = rForcedRelease;

endmodule

// File: tb/tb_kes_channel_arbiter.sv
// Bench for kes_channel_arbiter: three instances (4ch/limit 16, 4ch/limit 2,
// 8ch/unlimited) share stimulus and are checked every cycle against a
// timeline model, plus directed scenarios with literal expectations.
module tb_kes_channel_arbiter;

  logic       clk   = 1'b0;
  logic       rstN  = 1'b0;
  logic [7:0] req   = 8'd0;
  logic [7:0] last  = 8'd0;
  logic       avail = 1'b0;

  always #5 clk = ~clk;

  kes_arb_if #(.CHANNEL_COUNT(4), .CHANNEL_BITS(2)) busA ();
  kes_arb_if #(.CHANNEL_COUNT(4), .CHANNEL_BITS(2)) busB ();
  kes_arb_if #(.CHANNEL_COUNT(8), .CHANNEL_BITS(3)) busC ();

  assign busA.iRequestChannel = req[3:0];
  assign busA.iLastChunk      = last[3:0];
  assign busA.iKESAvail       = avail;
  assign busB.iRequestChannel = req[3:0];
  assign busB.iLastChunk      = last[3:0];
  assign busB.iKESAvail       = avail;
  assign busC.iRequestChannel = req;
  assign busC.iLastChunk      = last;
  assign busC.iKESAvail       = avail;

  kes_channel_arbiter #(.CHANNEL_COUNT(4), .CHANNEL_BITS(2), .MAX_CHUNKS(16))
    dutA (.iClock(clk), .iResetN(rstN), .bus(busA));
  kes_channel_arbiter #(.CHANNEL_COUNT(4), .CHANNEL_BITS(2), .MAX_CHUNKS(2))
    dutB (.iClock(clk), .iResetN(rstN), .bus(busB));
  kes_channel_arbiter #(.CHANNEL_COUNT(8), .CHANNEL_BITS(3), .MAX_CHUNKS(0))
    dutC (.iClock(clk), .iResetN(rstN), .bus(busC));

  int nChecks = 0;
  int nErrors = 0;
  int cyc     = 0;

  int mN[3]   = '{4, 4, 8};
  int mMax[3] = '{16, 2, 0};
  // Model: owner (-1 = nobody), cycle numbers of scheduled/last pulse and
  // of a forced-release pulse, chunks sent, next search start, shown index
  int mOwner[3], mPtr[3], mChNum[3], mCount[3];
  int mNextPulse[3], mLastPulse[3], mForcedAt[3];

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < 3; k++) begin
      mOwner[k] = -1; mPtr[k] = 0; mChNum[k] = 0; mCount[k] = 0;
      mNextPulse[k] = -1; mLastPulse[k] = -100; mForcedAt[k] = -1;
    end
  endfunction

  // Advance model k across the end of cycle c using the inputs of cycle c
  function automatic void modelStep(int k, int c);
    int mask;
    mask = (1 << mN[k]) - 1;
    if (mOwner[k] < 0) begin
      if (((int'(req) & mask) != 0) && avail) begin
        for (int i = 0; i < mN[k]; i++) begin
          int ch;
          ch = (mPtr[k] + i) % mN[k];
          if (req[ch] && mOwner[k] < 0) mOwner[k] = ch;
        end
        mPtr[k] = (mOwner[k] + 1) % mN[k];
        mChNum[k] = mOwner[k];
        mCount[k] = 0;
        mNextPulse[k] = c + 2;
        mLastPulse[k] = -100;
      end
    end else if (c == mNextPulse[k]) begin
      mCount[k] = (mCount[k] < 255) ? mCount[k] + 1 : 255;
      mLastPulse[k] = c;
      mNextPulse[k] = -1;
    end else if (c == mLastPulse[k] + 1) begin
      if (last[mOwner[k]]) mOwner[k] = -1;
      else if (mMax[k] != 0 && mCount[k] == mMax[k]) begin
        mOwner[k] = -1;
        mForcedAt[k] = c + 1;
      end
    end else if (mNextPulse[k] < 0) begin
      if (!req[mOwner[k]]) mOwner[k] = -1;
      else if (avail) mNextPulse[k] = c + 1;
    end
  endfunction

  function automatic int actKes(int k);
    case (k)
      0: return int'(busA.oKESAvail);
      1: return int'(busB.oKESAvail);
      default: return int'(busC.oKESAvail);
    endcase
  endfunction
  function automatic int actCh(int k);
    case (k)
      0: return int'(busA.oChannelNumber);
      1: return int'(busB.oChannelNumber);
      default: return int'(busC.oChannelNumber);
    endcase
  endfunction
  function automatic int actValid(int k);
    case (k)
      0: return int'(busA.oChannelValid);
      1: return int'(busB.oChannelValid);
      default: return int'(busC.oChannelValid);
    endcase
  endfunction
  function automatic int actForced(int k);
    case (k)
      0: return int'(busA.oForcedRelease);
      1: return int'(busB.oForcedRelease);
      default: return int'(busC.oForcedRelease);
    endcase
  endfunction

  function automatic int ohIdx(int v);
    for (int i = 0; i < 16; i++) if (v == (1 << i)) return i;
    return -1;
  endfunction

  task automatic compareAll();
    for (int k = 0; k < 3; k++) begin
      int expKes;
      expKes = (mOwner[k] >= 0 && mNextPulse[k] == cyc) ? (1 << mOwner[k]) : 0;
      check($sformatf("model_kes[%0d]", k), actKes(k), expKes);
      check($sformatf("model_chnum[%0d]", k), actCh(k), mChNum[k]);
      check($sformatf("model_valid[%0d]", k), actValid(k), (mOwner[k] >= 0) ? 1 : 0);
      check($sformatf("model_forced[%0d]", k), actForced(k), (mForcedAt[k] == cyc) ? 1 : 0);
    end
  endtask

  // One clock: model steps at the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    if (!rstN) modelReset();
    else for (int k = 0; k < 3; k++) modelStep(k, cyc);
    cyc++;
    @(negedge clk);
    compareAll();
  endtask

  task automatic doReset();
    req = 8'd0; last = 8'd0; avail = 1'b0;
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  initial begin
    int seq[$];
    int t0, firstCyc, secondCyc, pulses, forcedCnt;

    modelReset();
    doReset();
    check("reset_valid", int'(busA.oChannelValid), 0);
    check("reset_kes", int'(busA.oKESAvail), 0);
    check("reset_chnum", int'(busA.oChannelNumber), 0);

    // All four requesting, every chunk last: 0,1,2,3,0 with pulse at T+2
    req = 8'h0F; last = 8'hFF; avail = 1'b1;
    t0 = cyc; firstCyc = -1; secondCyc = -1; seq.delete();
    for (int i = 0; i < 40 && seq.size() < 5; i++) begin
      tick();
      if (busA.oKESAvail != 4'd0) begin
        if (firstCyc < 0) firstCyc = cyc;
        else if (secondCyc < 0) secondCyc = cyc;
        seq.push_back(ohIdx(int'(busA.oKESAvail)));
      end
    end
    check("rr_first_pulse_cycle", firstCyc, t0 + 2);
    check("rr_second_pulse_cycle", secondCyc, t0 + 6);
    check("rr_grant_count", seq.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_order[%0d]", i), (i < seq.size()) ? seq[i] : -1, i % 4);

    // Channel 2 alone, three non-last chunks then a last one
    doReset();
    req = 8'h04; last = 8'h00; avail = 1'b1; pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (busA.oChannelValid) check("multi_chnum", int'(busA.oChannelNumber), 2);
      if (busA.oKESAvail != 4'd0) begin
        pulses++;
        check("multi_pulse_value", int'(busA.oKESAvail), 4);
        if (pulses == 4) last = 8'h04;
      end
      if (pulses == 4 && !busA.oChannelValid) break;
    end
    check("multi_pulse_count", pulses, 4);
    check("multi_idle_after", int'(busA.oChannelValid), 0);
    req = 8'h00;
    tick();

    // Limit of 2 chunks on channel 1, channel 2 waiting behind it
    doReset();
    req = 8'h06; last = 8'h00; avail = 1'b1; seq.delete(); forcedCnt = 0;
    for (int i = 0; i < 60 && seq.size() < 3; i++) begin
      tick();
      if (busB.oForcedRelease && seq.size() < 3) forcedCnt++;
      if (busB.oKESAvail != 4'd0) seq.push_back(ohIdx(int'(busB.oKESAvail)));
    end
    check("limit_pulse_count", seq.size(), 3);
    check("limit_pulse0", (seq.size() > 0) ? seq[0] : -1, 1);
    check("limit_pulse1", (seq.size() > 1) ? seq[1] : -1, 1);
    check("limit_pulse2", (seq.size() > 2) ? seq[2] : -1, 2);
    check("limit_forced_count", forcedCnt, 1);

    // Abandon from standby: request drops together with solver ready
    doReset();
    req = 8'h01; last = 8'h00; avail = 1'b1; pulses = 0;
    for (int i = 0; i < 10 && pulses == 0; i++) begin
      tick();
      if (busA.oKESAvail != 4'd0) pulses++;
    end
    check("abandon_first_pulse", pulses, 1);
    avail = 1'b0;
    tick();
    tick();
    check("abandon_standby_valid", int'(busA.oChannelValid), 1);
    req = 8'h00; avail = 1'b1; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busA.oKESAvail != 4'd0) pulses++;
    end
    check("abandon_no_pulse", pulses, 0);
    check("abandon_idle", int'(busA.oChannelValid), 0);

    // Asynchronous reset during a chunk pulse
    doReset();
    req = 8'h0F; last = 8'hFF; avail = 1'b1; seq.delete();
    for (int i = 0; i < 30 && seq.size() < 2; i++) begin
      tick();
      if (busA.oKESAvail != 4'd0) seq.push_back(ohIdx(int'(busA.oKESAvail)));
    end
    check("areset_pre_grant", (seq.size() > 1) ? seq[1] : -1, 1);
    #1 rstN = 1'b0;
    #1;
    check("areset_kes_now", int'(busA.oKESAvail), 0);
    check("areset_valid_now", int'(busA.oChannelValid), 0);
    check("areset_chnum_now", int'(busA.oChannelNumber), 0);
    modelReset();
    tick();
    tick();
    rstN = 1'b1;
    firstCyc = -1;
    for (int i = 0; i < 20 && firstCyc < 0; i++) begin
      tick();
      if (busA.oKESAvail != 4'd0) firstCyc = ohIdx(int'(busA.oKESAvail));
    end
    check("areset_first_grant", firstCyc, 0);

    // Eight channels, pointer moved to 7, then requests on 7 and 0
    doReset();
    req = 8'h40; last = 8'hFF; avail = 1'b1; firstCyc = -1;
    for (int i = 0; i < 10 && firstCyc < 0; i++) begin
      tick();
      if (busC.oKESAvail != 8'd0) firstCyc = ohIdx(int'(busC.oKESAvail));
    end
    check("wrap_setup_grant", firstCyc, 6);
    req = 8'h81; seq.delete();
    for (int i = 0; i < 30 && seq.size() < 2; i++) begin
      tick();
      if (busC.oKESAvail != 8'd0) seq.push_back(ohIdx(int'(busC.oKESAvail)));
    end
    check("wrap_grant0", (seq.size() > 0) ? seq[0] : -1, 7);
    check("wrap_grant1", (seq.size() > 1) ? seq[1] : -1, 0);

    // Random traffic against the model
    doReset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      last  = 8'($urandom & $urandom);
      avail = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
